// File: rtl/dpram_arb_pkg.sv
// ---------------------------------------------------------------------------
// dpram_arb_pkg
// Shared definitions for the dual-port-RAM arbiter slice:
//   - arb_state_e : FSM state encoding (IDLE = 0, ISSUE = 1, RD_WAIT = 2)
//   - DEF_ADDR_W  : default RAM address width (4096 locations)
//   - DEF_DATA_W  : default RAM data width
//   - ptr_width() : width of a round-robin pointer for a given requester count
// ---------------------------------------------------------------------------
package dpram_arb_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        RD_WAIT = 2'd2
    } arb_state_e;

    // A single requester still needs a 1-bit pointer so the ports stay legal.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches req starting at index rr_ptr and
// wrapping around; the first asserted request wins.
// Ports:
//   req    in  NUM_REQ  request vector
//   rr_ptr in  PTR_W    index where the search starts
//   sel    out NUM_REQ  one-hot winner (all zero when nothing requests)
//   valid  out 1        some request was found
// ---------------------------------------------------------------------------
module rr_pick
    import dpram_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = ptr_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] sel,
    output logic               valid
);

    logic [PTR_W-1:0] idx;

    // Walk the candidates in priority order rr_ptr, rr_ptr+1, ... (mod NUM_REQ)
    // and stop claiming once the first requester has been found.
    always_comb begin
        sel   = '0;
        valid = 1'b0;
        idx   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = PTR_W'((int'(rr_ptr) + off) % NUM_REQ);
            if (!valid && req[idx]) begin
                sel[idx] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dpram_arbiter.sv
// ---------------------------------------------------------------------------
// dpram_arbiter
// Shares one synchronous RAM port between NUM_REQ requesters. Writes issue
// back to back; a read occupies ISSUE then RD_WAIT and returns data two cycles
// after its grant. All outputs are registered.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req/req_we          per-requester request level and write flag
//   req_addr/req_wdata  flattened, requester i at [i*W +: W]
//   gnt                 one-hot grant pulse (ISSUE cycle)
//   rdata/rvalid        shared read data, one-hot read-valid pulse
//   ram_wena/ram_addr/ram_wdata/ram_rdata   RAM port
// Build option:
//   DPRAM_ARB_PRIO0_EN  requester 0 wins whenever it requests and does not
//                       move the round-robin pointer.
// ---------------------------------------------------------------------------
module dpram_arbiter
    import dpram_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_we,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [DATA_W-1:0]           rdata,
    output logic [NUM_REQ-1:0]          rvalid,
    output logic                        ram_wena,
    output logic [ADDR_W-1:0]           ram_addr,
    output logic [DATA_W-1:0]           ram_wdata,
    input  logic [DATA_W-1:0]           ram_rdata
);

    localparam int PTR_W = ptr_width(NUM_REQ);

    arb_state_e         state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_REQ-1:0] rd_owner;

    logic [NUM_REQ-1:0] rr_sel;
    logic               rr_valid;
    logic [NUM_REQ-1:0] win_sel;
    logic               win_valid;
    logic               win_adv;
    logic [PTR_W-1:0]   win_idx;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_wdata;
    logic               win_we;
    logic [PTR_W-1:0]   next_ptr;
    logic               decision;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .sel    (rr_sel),
        .valid  (rr_valid)
    );

`ifdef DPRAM_ARB_PRIO0_EN
    // Requester 0 overrides the round-robin choice and leaves rr_ptr alone.
    always_comb begin
        win_sel   = rr_sel;
        win_valid = rr_valid;
        win_adv   = rr_valid;
        if (req[0]) begin
            win_sel   = NUM_REQ'(1);
            win_valid = 1'b1;
            win_adv   = 1'b0;
        end
    end
`else
    always_comb begin
        win_sel   = rr_sel;
        win_valid = rr_valid;
        win_adv   = rr_valid;
    end
`endif

    // Mux the winner's request fields; win_sel is one-hot so at most one hit.
    always_comb begin
        win_idx   = '0;
        win_addr  = '0;
        win_wdata = '0;
        win_we    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_sel[i]) begin
                win_idx   = PTR_W'(i);
                win_addr  = req_addr[i*ADDR_W +: ADDR_W];
                win_wdata = req_wdata[i*DATA_W +: DATA_W];
                win_we    = req_we[i];
            end
        end
    end

    assign next_ptr = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

    // Only a read in ISSUE skips arbitration; every other edge is a decision.
    assign decision = !((state == ISSUE) && !ram_wena);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            rd_owner  <= '0;
            gnt       <= '0;
            rvalid    <= '0;
            rdata     <= '0;
            ram_wena  <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            rvalid <= '0;
            // The RAM answered the read during RD_WAIT; hand it to its owner.
            if (state == RD_WAIT) begin
                rdata  <= ram_rdata;
                rvalid <= rd_owner;
            end
            if (decision) begin
                if (win_valid) begin
                    state     <= ISSUE;
                    gnt       <= win_sel;
                    rd_owner  <= win_sel;
                    ram_wena  <= win_we;
                    ram_addr  <= win_addr;
                    ram_wdata <= win_wdata;
                    if (win_adv) begin
                        rr_ptr <= next_ptr;
                    end
                end else begin
                    state    <= IDLE;
                    gnt      <= '0;
                    ram_wena <= 1'b0;
                end
            end else begin
                state    <= RD_WAIT;
                gnt      <= '0;
                ram_wena <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dpram_arbiter.md
DPRAM_ARBITER -- requirements
Module: dpram_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 3: number of requesters.
REQ-002 Parameter ADDR_W, default 12: RAM address width (4096 locations).
REQ-003 Parameter DATA_W, default 8: RAM data width.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 req  in  NUM_REQ  per-requester access request, level.
REQ-008 req_we  in  NUM_REQ  per-requester 1=write, 0=read.
REQ-009 req_addr  in  NUM_REQ*ADDR_W  flattened addresses, requester i at bits [i*ADDR_W +: ADDR_W].
REQ-010 req_wdata  in  NUM_REQ*DATA_W  flattened write data, same packing.
REQ-011 gnt  out  NUM_REQ  one-hot grant pulse, one cycle.
REQ-012 rdata  out  DATA_W  read data, shared by all requesters.
REQ-013 rvalid  out  NUM_REQ  one-hot read-data-valid pulse, one cycle.
REQ-014 ram_wena  out  1  RAM port write enable.
REQ-015 ram_addr  out  ADDR_W  RAM port address.
REQ-016 ram_wdata  out  DATA_W  RAM port write data (tristate resolved outside this block).
REQ-017 ram_rdata  in  DATA_W  RAM port read data.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, RD_WAIT; all outputs SHALL be registered.
REQ-019 Decision point: any rising edge in IDLE, in ISSUE with a write, or in RD_WAIT.
REQ-020 At a decision point with req != 0, the block SHALL select one index i, latch req_addr/req_we/req_wdata[i] into ram_addr/ram_wena/ram_wdata, set gnt = 1<<i and enter ISSUE.
REQ-021 At a decision point with req == 0, the block SHALL enter IDLE with ram_wena = 0 and gnt = 0.
REQ-022 gnt SHALL be high only during the ISSUE cycle; ram_wena SHALL be high only in ISSUE when the access is a write.
REQ-023 Selection SHALL be round-robin: search starts at rr_ptr, and rr_ptr becomes (i+1) mod NUM_REQ after a grant to i.
REQ-024 A read ISSUE SHALL be followed by RD_WAIT; at the RD_WAIT edge, rdata <= ram_rdata and rvalid = 1<<i for one cycle.
REQ-025 Read latency: gnt in cycle N and rvalid/rdata valid in cycle N+2; write throughput is 1 per cycle; read throughput is 1 per 2 cycles.
REQ-026 A requester SHALL hold req/we/addr/wdata stable until it sees gnt, and SHALL drop req in the gnt cycle unless it has another access; req high at a decision edge is a new request.
REQ-027 A requester that deasserts req before its grant SHALL NOT be granted; no error is flagged.
REQ-028 rdata SHALL hold its last value between rvalid pulses.
REQ-029 ram_addr and ram_wdata SHALL hold their last value in IDLE.

Reset
REQ-030 On rst_n low, the block SHALL immediately set state = IDLE, rr_ptr = 0, gnt = 0, rvalid = 0, rdata = 0, ram_wena = 0, ram_addr = 0 and ram_wdata = 0.
REQ-031 A reset asserted during ISSUE or RD_WAIT SHALL abort the access without producing rvalid; a write in flight is not guaranteed to land.
REQ-032 The first decision point after rst_n rises SHALL be the first rising edge with rst_n high.

Configuration
REQ-033 With DPRAM_ARB_PRIO0_EN defined, requester 0 SHALL win every decision point where req[0] = 1, regardless of rr_ptr; rr_ptr is not advanced by requester-0 grants.
REQ-034 Without DPRAM_ARB_PRIO0_EN, all requesters SHALL be served pure round-robin per REQ-023.

Structure
REQ-035 Package dpram_arb_pkg SHALL hold the state encoding (IDLE = 0, ISSUE = 1, RD_WAIT = 2) and the default ADDR_W/DATA_W constants.
REQ-036 Sub-module rr_pick SHALL be a combinational round-robin picker (inputs req, rr_ptr; outputs one-hot sel and valid).

Verification
REQ-037 Single write: req[1] = 1, we = 1, addr 0x123, wdata 0xA5 -> gnt = 010 next cycle, ram_wena = 1, ram_addr = 0x123, ram_wdata = 0xA5 for exactly one cycle.
REQ-038 Read latency: RAM model preloaded 0x123 = 0x5A, req[2] read -> gnt = 100 in cycle N, rvalid = 100 and rdata = 0x5A in cycle N+2.
REQ-039 Fairness: all three requesters hold continuous writes for 9 grants -> grant order 0,1,2,0,1,2,0,1,2 with no idle cycles.
REQ-040 Priority: with DPRAM_ARB_PRIO0_EN, req = 111 held continuously -> every grant goes to requester 0; without the macro, expect the REQ-039 order.
REQ-041 Reset mid-read: rst_n low in the RD_WAIT cycle -> gnt, rvalid and ram_wena are 0 at once, no rvalid after release, and the first grant after release goes to requester 0.
REQ-042 Withdrawn request: req[1] pulses high for one cycle while requester 0 is in ISSUE, then drops -> requester 1 is never granted.
